// File: rtl/async_rr_merge_pkg.sv
// async_rr_merge_pkg
// Shared definitions for the round-robin merge controller.
//   ST_ARB / ST_FETCH / ST_SEND : controller state encoding (2'd3 is illegal)
//   clog2()                     : ceiling log2 for elaboration-time sizing
//   id_bits()                   : lane index width, never narrower than 1 bit
package async_rr_merge_pkg;

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  // A single lane still needs a 1-bit index so dout_id stays a legal port.
  function automatic int id_bits(input int lanes);
    return (lanes <= 1) ? 1 : clog2(lanes);
  endfunction

endpackage

// File: rtl/async_rr_merge_if.sv
// async_rr_merge_if
// Bundles the lane-side pull handshake, the downstream handshake and the
// status outputs of the merge controller.
//   lane_vld, req_l, ack_l, din : upstream lanes (one bit / slice per lane)
//   req_r, ack_r, dout, dout_id : downstream consumer
//   busy, count                 : status and per-lane grant counters
// Modport master is the merge controller; modport slave is its environment
// (producers plus consumer).
interface async_rr_merge_if
  import async_rr_merge_pkg::*;
#(
  parameter int data_width = 32,
  parameter int num_lanes  = 4
);
  localparam int id_width = id_bits(num_lanes);

  logic [num_lanes-1:0]            lane_vld;
  logic [num_lanes-1:0]            req_l;
  logic [num_lanes-1:0]            ack_l;
  logic [num_lanes*data_width-1:0] din;
  logic                            req_r;
  logic                            ack_r;
  logic [data_width-1:0]           dout;
  logic [id_width-1:0]             dout_id;
  logic                            busy;
  logic [num_lanes*32-1:0]         count;

  modport master (
    input  lane_vld, ack_l, din, req_r,
    output req_l, ack_r, dout, dout_id, busy, count
  );

  modport slave (
    output lane_vld, ack_l, din, req_r,
    input  req_l, ack_r, dout, dout_id, busy, count
  );

endinterface

// File: rtl/async_rr_merge_rr_picker.sv
// rr_picker
// Combinational round-robin selector: returns the first set bit of vld,
// scanning upward from last+1 and wrapping modulo num_lanes.
//   vld     : lanes currently holding a token
//   last    : lane served most recently
//   gnt_idx : selected lane (0 when none is valid)
//   any     : at least one lane is valid
module rr_picker #(
  parameter int num_lanes = 4,
  parameter int id_width  = 2
) (
  input  logic [num_lanes-1:0] vld,
  input  logic [id_width-1:0]  last,
  output logic [id_width-1:0]  gnt_idx,
  output logic                 any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest valid lane after
  // 'last' is the one left standing; offset num_lanes is 'last' itself.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = num_lanes; k >= 1; k--) begin
      idx = (int'(last) + k) % num_lanes;
      if (vld[idx]) begin
        gnt_idx = id_width'(idx);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_rr_merge.sv
// async_rr_merge
// Round-robin N:1 merge. Pulls one token at a time from a valid lane via
// req_l/ack_l, buffers it, then hands it downstream on a one-cycle ack_r
// strobe together with the source lane index. Counts grants per lane.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : async_rr_merge_if master modport (lanes, downstream, status)
module async_rr_merge
  import async_rr_merge_pkg::*;
#(
  parameter int data_width = 32,
  parameter int num_lanes  = 4
) (
  input logic             clk,
  input logic             rst,
  async_rr_merge_if.master bus
);

  localparam int id_width = id_bits(num_lanes);
  localparam logic [num_lanes-1:0] lane_one = num_lanes'(1);

  logic [1:0]            state_reg;
  logic [id_width-1:0]   gnt_reg;
  logic [id_width-1:0]   last_reg;
  logic [data_width-1:0] tok_buf_reg;
  logic [num_lanes-1:0]  req_l_reg;
  logic                  ack_r_reg;
  logic [data_width-1:0] dout_reg;
  logic [id_width-1:0]   dout_id_reg;

  logic [id_width-1:0]   pick_idx;
  logic                  pick_any;
  logic                  capture;

  rr_picker #(
    .num_lanes (num_lanes),
    .id_width  (id_width)
  ) u_picker (
    .vld     (bus.lane_vld),
    .last    (last_reg),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Only the granted lane's strobe counts, and only while fetching.
  assign capture = (state_reg == ST_FETCH) && bus.ack_l[gnt_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_ARB;
      gnt_reg     <= '0;
      last_reg    <= id_width'(num_lanes - 1);
      tok_buf_reg <= '0;
      req_l_reg   <= '0;
      ack_r_reg   <= 1'b0;
      dout_reg    <= '0;
      dout_id_reg <= '0;
    end else begin
      ack_r_reg <= 1'b0;
      case (state_reg)
        ST_ARB: begin
          if (pick_any) begin
            req_l_reg <= lane_one << pick_idx;
            gnt_reg   <= pick_idx;
            state_reg <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // req_l stays up until the ack arrives, even if lane_vld drops.
          if (capture) begin
            tok_buf_reg <= bus.din[int'(gnt_reg)*data_width +: data_width];
            req_l_reg   <= '0;
            last_reg    <= gnt_reg;
            state_reg   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.req_r && !ack_r_reg) begin
            ack_r_reg   <= 1'b1;
            dout_reg    <= tok_buf_reg;
            dout_id_reg <= gnt_reg;
            state_reg   <= ST_ARB;
          end
        end
        default: begin
          req_l_reg <= '0;
          state_reg <= ST_ARB;
        end
      endcase
    end
  end

  // One free-running-on-grant counter per lane, wrapping at 2^32.
  for (genvar gi = 0; gi < num_lanes; gi++) begin : g_count
    logic [31:0] lane_count;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lane_count <= '0;
      end else if (capture && (gnt_reg == id_width'(gi))) begin
        lane_count <= lane_count + 32'd1;
      end
    end

    assign bus.count[gi*32 +: 32] = lane_count;
  end

  assign bus.req_l   = req_l_reg;
  assign bus.ack_r   = ack_r_reg;
  assign bus.dout    = dout_reg;
  assign bus.dout_id = dout_id_reg;
  assign bus.busy    = (state_reg != ST_ARB);

endmodule

// File: tb/tb_async_rr_merge.sv
// tb_async_rr_merge
// Scoreboard bench for async_rr_merge (4 lanes, 32-bit tokens). Tests push
// hand-computed {lane, token} pairs; a monitor pops and compares on every
// ack_r strobe. A lane model answers each req_l with a one-cycle ack_l.
module tb_async_rr_merge;

  localparam int DW = 32;
  localparam int NL = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  async_rr_merge_if #(.data_width(DW), .num_lanes(NL)) bus ();

  async_rr_merge #(.data_width(DW), .num_lanes(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   ack_times[$];
  int   cycle = 0;

  int          remaining[NL];
  int          seq[NL];
  logic [31:0] base[NL];
  bit          spur_arm = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic push(input int id, input logic [31:0] data);
    exp_t e;
    e.id   = 2'(id);
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Lane model: samples req_l between edges, raises ack_l for one cycle
  // after the following edge with the next token of that lane.
  initial begin
    logic [NL-1:0] req_samp;
    bus.ack_l    = '0;
    bus.din      = '0;
    bus.lane_vld = '0;
    forever begin
      @(negedge clk);
      req_samp = bus.req_l;
      @(posedge clk);
      #1;
      for (int i = 0; i < NL; i++) begin
        if (bus.ack_l[i]) begin
          bus.ack_l[i] = 1'b0;
        end else if (req_samp[i] && remaining[i] > 0) begin
          bus.ack_l[i]         = 1'b1;
          bus.din[i*DW +: DW]  = base[i] + 32'(seq[i]);
          seq[i]               = seq[i] + 1;
          remaining[i]         = remaining[i] - 1;
        end
      end
      if (spur_arm && bus.req_l[2]) begin
        bus.ack_l[0]   = 1'b1;
        bus.din[31:0]  = 32'hDEAD_BEEF;
        spur_arm       = 1'b0;
      end
      for (int i = 0; i < NL; i++) bus.lane_vld[i] = (remaining[i] > 0);
    end
  end

  // Monitor: one comparison per delivered token, plus structural checks.
  initial begin
    exp_t e;
    bit   prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      n_checks++;
      if ($countones(bus.req_l) > 1) begin
        n_fail++;
        $display("FAIL req_onehot: got %b expected at most one bit", bus.req_l);
      end
      if (bus.ack_r) begin
        ack_times.push_back(cycle);
        check("ack_r_gap", 64'(prev_ack), 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_token: got id %0d data %0h expected none", bus.dout_id, bus.dout);
        end else begin
          e = exp_q.pop_front();
          $display("xfer id=%0d data=%0h (want id=%0d data=%0h)", bus.dout_id, bus.dout, e.id, e.data);
          check("dout", 64'(bus.dout), 64'(e.data));
          check("dout_id", 64'(bus.dout_id), 64'(e.id));
        end
      end
      prev_ack = bus.ack_r;
    end
  end

  task automatic clear_lanes();
    for (int i = 0; i < NL; i++) begin
      remaining[i] = 0;
      seq[i]       = 0;
    end
  endtask

  task automatic do_reset();
    clear_lanes();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_busy, stall_req, stall_ack, stall_dout;
    bit found;
    bus.req_r = 1'b0;
    clear_lanes();
    for (int i = 0; i < NL; i++) base[i] = '0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("rst_req_l", 64'(bus.req_l), 64'd0);
    check("rst_ack_r", 64'(bus.ack_r), 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_dout_id", 64'(bus.dout_id), 64'd0);
    check("rst_count", 64'(|bus.count), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;

    // Single lane 2, tokens 0,1,2, downstream always requesting.
    bus.req_r = 1'b1;
    base[2] = 32'd0;
    ack_times.delete();
    push(2, 32'd0); push(2, 32'd1); push(2, 32'd2);
    remaining[2] = 3;
    wait_idle(200);
    check("t1_pulses", 64'(ack_times.size()), 64'd3);
    if (ack_times.size() == 3) begin
      check("t1_period_a", 64'(ack_times[1] - ack_times[0]), 64'd4);
      check("t1_period_b", 64'(ack_times[2] - ack_times[1]), 64'd4);
    end
    check("t1_count2", 64'(bus.count[2*32 +: 32]), 64'd3);

    // All four lanes, two tokens each: 0,1,2,3,0,1,2,3 after reset.
    do_reset();
    for (int i = 0; i < NL; i++) base[i] = 32'hA000_0000 + 32'(i << 8);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NL; i++) push(i, base[i] + 32'(r));
    for (int i = 0; i < NL; i++) remaining[i] = 2;
    wait_idle(400);
    for (int i = 0; i < NL; i++) check($sformatf("t2_count%0d", i), 64'(bus.count[i*32 +: 32]), 64'd2);

    // Lanes 1 and 3 only: 1,3,1,3 after reset.
    do_reset();
    base[1] = 32'h1111_0000;
    base[3] = 32'h3333_0000;
    push(1, 32'h1111_0000); push(3, 32'h3333_0000);
    push(1, 32'h1111_0001); push(3, 32'h3333_0001);
    remaining[1] = 2;
    remaining[3] = 2;
    wait_idle(400);
    check("t3_count1", 64'(bus.count[1*32 +: 32]), 64'd2);
    check("t3_count3", 64'(bus.count[3*32 +: 32]), 64'd2);

    // Downstream stall for 20 cycles with a token buffered in SEND.
    do_reset();
    bus.req_r = 1'b0;
    base[1] = 32'h5555_0000;
    push(1, 32'h5555_0000); push(1, 32'h5555_0001);
    remaining[1] = 2;
    repeat (10) @(negedge clk);
    stall_busy = 0; stall_req = 0; stall_ack = 0; stall_dout = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.busy) stall_busy++;
      if (bus.req_l != '0) stall_req++;
      if (bus.ack_r) stall_ack++;
      if (bus.dout != '0) stall_dout++;
    end
    check("t4_busy_cycles", 64'(stall_busy), 64'd20);
    check("t4_req_cycles", 64'(stall_req), 64'd0);
    check("t4_ack_cycles", 64'(stall_ack), 64'd0);
    check("t4_dout_changes", 64'(stall_dout), 64'd0);
    ack_times.delete();
    bus.req_r = 1'b1;
    wait_idle(200);
    check("t4_pulses", 64'(ack_times.size()), 64'd2);

    // Spurious ack on lane 0 while lane 2 is granted.
    do_reset();
    base[2] = 32'h2222_0000;
    push(2, 32'h2222_0000);
    remaining[2] = 1;
    spur_arm = 1'b1;
    wait_idle(200);
    check("t5_count0", 64'(bus.count[0 +: 32]), 64'd0);
    check("t5_count2", 64'(bus.count[2*32 +: 32]), 64'd1);

    // Reset pulse during FETCH of lane 3 (last=2 from previous token).
    clear_lanes();
    for (int i = 0; i < NL; i++) base[i] = 32'h6000_0000 + 32'(i << 8);
    for (int i = 0; i < NL; i++) remaining[i] = 1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.req_l != '0) found = 1'b1;
    end
    check("t6_fetch_seen", 64'(found), 64'd1);
    check("t6_granted_lane", 64'(bus.req_l), 64'h8);
    rst = 1'b0;
    #1;
    check("t6_req_l", 64'(bus.req_l), 64'd0);
    check("t6_ack_r", 64'(bus.ack_r), 64'd0);
    check("t6_dout", 64'(bus.dout), 64'd0);
    check("t6_dout_id", 64'(bus.dout_id), 64'd0);
    check("t6_count", 64'(|bus.count), 64'd0);
    check("t6_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < NL; i++) push(i, base[i]);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
